// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART transmit stage
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous FIFO with combinational head and occupancy count
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stage.sv
// rtl/uart_tx_stage.sv - buffered UART 8N1 transmitter fed by a valid/ready byte stream
module uart_tx_stage
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_W - 1);

  state_t             state, state_n;
  logic [BW-1:0]      bcnt, bcnt_n;
  logic [2:0]         bit_idx, bit_idx_n;
  logic [DATA_W-1:0]  shift, shift_n;
  logic               tx_n;
  logic               bit_end;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [DATA_W-1:0]  head;

  // Ready depends only on registered occupancy, so a same-edge pop never frees a slot early.
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || (level != '0);
  assign bit_end  = (bcnt == BCNT_LAST);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      bcnt    <= bcnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    bcnt_n    = bcnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    tx_n      = 1'b1;

    if (state != IDLE) begin
      bcnt_n = bit_end ? '0 : bcnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_idx == LAST_BIT) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        // Chaining straight into the next start bit keeps frames gapless.
        if (bit_end) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (pop) begin
      shift_n = head;
      state_n = START;
      bcnt_n  = '0;
    end

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_stage.sv
// tb/tb_uart_tx_stage.sv - directed self-checking bench for uart_tx_stage
module tb_uart_tx_stage;
  import uart_tx_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FLEN  = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] level;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_stage #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at the negedge of the first start-bit cycle; leaves one cycle past the frame.
  task automatic check_frame(input logic [7:0] b);
    logic [7:0] v;
    int bitn;
    logic e;
    v = b;
    for (int i = 0; i < FLEN; i++) begin
      bitn = i / CPB;
      if (bitn == 0) e = 1'b0;
      else if (bitn == FRAME_BITS - 1) e = 1'b1;
      else e = v[bitn-1];
      chk($sformatf("frame%02h_c%0d", b, i), {31'd0, tx}, {31'd0, e});
      @(negedge clk);
    end
  endtask

  task automatic wait_low(input string tag);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, (n < 200)}, 32'd1);
  endtask

  initial begin
    int full_cycles;
    int lows;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // reset behaviour
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_level", {29'd0, level}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_tx", {31'd0, tx}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_level", {29'd0, level}, 32'd0);

    // single byte, exact latency and frame
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("a5_pre_tx", {31'd0, tx}, 32'd1);
    chk("a5_pre_level", {29'd0, level}, 32'd1);
    chk("a5_pre_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("a5_pop_level", {29'd0, level}, 32'd0);
    check_frame(8'hA5);
    chk("a5_done_busy", {31'd0, busy}, 32'd0);
    chk("a5_done_tx", {31'd0, tx}, 32'd1);

    // burst with full FIFO and refused push on the pop edge
    fork
      begin
        for (int b = 1; b <= 5; b++) begin
          in_data  = 8'(b);
          in_valid = 1'b1;
          chk($sformatf("burst_ready_%0d", b), {31'd0, in_ready}, 32'd1);
          @(negedge clk);
        end
        in_data = 8'h06;
        full_cycles = 0;
        while (!in_ready && full_cycles < 100) begin
          chk("full_level", {29'd0, level}, 32'd4);
          full_cycles++;
          @(negedge clk);
        end
        chk("full_cycles", full_cycles, 32'd37);
        chk("refused_push_level", {29'd0, level}, 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        chk("sixth_accept_level", {29'd0, level}, 32'd4);
      end
      begin
        wait_low("burst_start");
        for (int b = 1; b <= 6; b++) begin
          check_frame(8'(b));
        end
        chk("burst_done_busy", {31'd0, busy}, 32'd0);
        chk("burst_done_level", {29'd0, level}, 32'd0);
      end
    join

    // reset mid-frame with two bytes queued
    in_data  = 8'h3C;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h11;
    @(negedge clk);
    chk("mid_start_tx", {31'd0, tx}, 32'd0);
    in_data = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("mid_bit3_tx", {31'd0, tx}, 32'd1);
    chk("mid_queued", {29'd0, level}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_level", {29'd0, level}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("mid_quiet_lows", lows, 32'd0);
    chk("mid_quiet_busy", {31'd0, busy}, 32'd0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_frame(8'h55);
    chk("f55_done_busy", {31'd0, busy}, 32'd0);

    // all-zero then all-one bytes, gapless
    in_data  = 8'h00;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    check_frame(8'h00);
    check_frame(8'hFF);
    chk("zf_done_busy", {31'd0, busy}, 32'd0);
    chk("zf_done_tx", {31'd0, tx}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_stage.md
Name: uart_tx_stage

Overview:
- Output stage downstream of the TinyTapeout user-project datapath: accepts result bytes over a valid/ready handshake and serialises them as UART 8N1 on one uo_out pin.
- Contains a small byte FIFO so the producing logic can burst results without waiting on line rate.
- The top level instantiates it, drives `rst = ~rst_n`, and routes `tx` to `uo_out[0]`.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit. Must be >= 2. Benches use 4.
- FIFO_DEPTH, 4, byte FIFO entries. Must be a power of 2 and >= 2.

Ports:
- clk  input  1  single system clock; everything is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  byte to transmit.
- in_valid  input  1  producer holds the byte valid; in_data is stable while in_valid=1 and in_ready=0.
- in_ready  output  1  FIFO can accept. Defined as `!full && !rst`.
- tx  output  1  registered serial line. Idle level is 1.
- busy  output  1  high when `(state != IDLE) || (level != 0)`.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, synchronous and active-high:
  - tx=1, state=IDLE, FIFO pointers and level cleared.
  - busy=0, in_ready=0 while rst=1, then 1 on the first cycle after reset.
- Reset mid-frame truncates the frame: tx=1 after the edge and all FIFO contents are discarded.
- Push: the FIFO writes in_data on an edge where `in_valid && in_ready`.
  - in_ready is derived only from the registered level.
  - A full FIFO refuses a push even if a pop happens on the same edge. The freed slot is visible the next cycle.
- Pop: on an edge where state=IDLE and level!=0:
  - the head byte loads into the shift register;
  - the FIFO pops;
  - state goes to START and tx goes to 0.
- Simultaneous push and pop with a non-full FIFO: level is unchanged and both operations take effect.
- FSM, with baud counter bcnt of width $clog2(CLKS_PER_BIT):
  - IDLE: tx=1. Pops as described above.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. Shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - On the final stop cycle, if level!=0, pop the next byte directly and go to START. No idle cycle appears between frames.
    - Otherwise go to IDLE.
- bcnt counts 0..CLKS_PER_BIT-1, wraps to 0 on every bit boundary, and is cleared on pop.
- Frame length is exactly 10*CLKS_PER_BIT cycles of tx.
- Latency: a handshake at edge k into an empty FIFO in IDLE gives level=1 after edge k, pop at edge k+1, and tx=0 visible after edge k+1.
- Capacity: bytes in flight = FIFO_DEPTH + 1 (the one in the shift register).
- level never exceeds FIFO_DEPTH. Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Decomposition:
- Package uart_tx_pkg:
  - state enum with IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - DATA_W=8;
  - FRAME_BITS=10.
- Sub-module byte_fifo (synchronous FIFO):
  - parameters DEPTH and WIDTH;
  - ports clk, rst, wr_en, wr_data, rd_en, rd_data (first-word visible combinationally), full, empty, level.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Hold rst=1 for 3 cycles, then release -> tx=1, busy=0, level=0 during and after reset; in_ready=0 during reset and 1 on the first cycle after.
2. Push 0xA5 once -> tx=0 from 1 cycle after the handshake edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 for 4 cycles; busy=0 exactly 40 cycles after tx first fell.
3. Hold in_valid=1 with data 0x01..0x06 -> first 5 bytes accepted; in_ready=0 with level=4; 6th byte accepted in the cycle after the first STOP completes; 6 back-to-back frames with no idle gap; decoded bytes in order.
4. FIFO full (level=4) and a pop occurs on the same edge as in_valid=1 -> push refused on that edge, in_ready=1 the next cycle, byte accepted then.
5. Assert rst for 1 cycle during DATA bit 3 of 0x3C with 2 bytes queued -> tx=1 on the next cycle, level=0, no further frames; a fresh push of 0x55 transmits correctly.
6. Push 0x00 then 0xFF -> line low for 9 bit-times then high; then low for 1 bit-time and high for 9; total 80 cycles with no gap.
